lsu_mem_stage: RTL and testbench

- Load/store unit directly downstream of the core datapath.
- Consumes the ALU address, store data and memory-enable/MemtoReg controls; drives a ready/handshake data RAM with byte enables; formats load data with sign/zero extension; returns the write-back value datareg_wr to the register bank.
- Asserts stall so the core's PC register holds while an access is outstanding.

---
 rtl/lsu_pkg.sv | 25 ++
 rtl/lsu_load_align.sv | 26 ++
 rtl/lsu_mem_stage.sv | 153 +++++++++++++++
 tb/tb_lsu_mem_stage.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} lsu_state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] LSU_ERR_DATA = 32'hDEAD_BEEF;

    // Unsigned variants exist only for loads; any unknown encoding is a word access.
    function automatic lsu_size_t access_size(input logic [2:0] f3, input logic is_store);
        if (f3 == F3_B || (!is_store && f3 == F3_BU))
            return SZ_B;
        else if (f3 == F3_H || (!is_store && f3 == F3_HU))
            return SZ_H;
        else
            return SZ_W;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane select and sign/zero extension.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'(rdata >> {lane, 3'b000});
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    value = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   value = {24'd0, byte_sel};
            F3_H:    value = {{16{half_sel[15]}}, half_sel};
            F3_HU:   value = {16'd0, half_sel};
            default: value = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory stage: drives a ready/handshake data RAM, formats loads, stalls the core.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              CLOCK,
    input  logic              RST_n,
    input  logic              ena_rd,
    input  logic              ena_wr,
    input  logic              MemtoReg_sig,
    input  logic [2:0]        funct3,
    input  logic [31:0]       alu_out_ext,
    input  logic [31:0]       dataram_wr,
    output logic [31:0]       datareg_wr,
    output logic              stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              misaligned_err,
    output logic              bus_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

    lsu_state_t state, state_nx;
    lsu_size_t  size;
    logic [CNT_W-1:0] cnt;
    logic [31:0] load_q, load_fmt, wdata_nx;
    logic [3:0]  be_nx;
    logic [1:0]  lane_q;
    logic [2:0]  f3_q;
    logic        is_load_q, aligned, start, misal;

    lsu_load_align u_align (
        .rdata  (mem_rdata),
        .lane   (lane_q),
        .funct3 (f3_q),
        .value  (load_fmt)
    );

    always_comb begin
        size = access_size(funct3, ena_wr);
        case (size)
            SZ_B: begin
                aligned  = 1'b1;
                be_nx    = 4'b0001 << alu_out_ext[1:0];
                wdata_nx = {4{dataram_wr[7:0]}};
            end
            SZ_H: begin
                aligned  = ~alu_out_ext[0];
                be_nx    = alu_out_ext[1] ? 4'b1100 : 4'b0011;
                wdata_nx = {2{dataram_wr[15:0]}};
            end
            default: begin
                aligned  = (alu_out_ext[1:0] == 2'b00);
                be_nx    = 4'b1111;
                wdata_nx = dataram_wr;
            end
        endcase
    end

    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        start    = 1'b0;
        misal    = 1'b0;
        case (state)
            IDLE: begin
                if (ena_rd | ena_wr) begin
                    if (aligned) begin
                        stall    = 1'b1;
                        start    = 1'b1;
                        state_nx = ACCESS;
                    end else begin
                        misal = 1'b1;
                    end
                end
            end
            ACCESS: begin
                stall = 1'b1;
                if (mem_ready || cnt == CNT_LIMIT)
                    state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (!RST_n) begin
            state          <= IDLE;
            cnt            <= '0;
            mem_addr       <= '0;
            mem_be         <= '0;
            mem_wdata      <= '0;
            mem_re         <= 1'b0;
            mem_we         <= 1'b0;
            load_q         <= '0;
            lane_q         <= '0;
            f3_q           <= '0;
            is_load_q      <= 1'b0;
            misaligned_err <= 1'b0;
            bus_err        <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        mem_addr  <= alu_out_ext[ADDR_W+1:2];
                        mem_be    <= be_nx;
                        mem_wdata <= wdata_nx;
                        mem_re    <= ~ena_wr;
                        mem_we    <= ena_wr;
                        lane_q    <= alu_out_ext[1:0];
                        f3_q      <= funct3;
                        is_load_q <= ~ena_wr;
                    end
                    if (misal) begin
                        misaligned_err <= 1'b1;
                        load_q         <= '0;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + CNT_W'(1);
                    // A ready on the final allowed cycle still wins over the timeout.
                    if (mem_ready) begin
                        mem_re <= 1'b0;
                        mem_we <= 1'b0;
                        if (is_load_q)
                            load_q <= load_fmt;
                    end else if (cnt == CNT_LIMIT) begin
                        mem_re  <= 1'b0;
                        mem_we  <= 1'b0;
                        bus_err <= 1'b1;
                        load_q  <= LSU_ERR_DATA;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    assign datareg_wr = MemtoReg_sig ? load_q : alu_out_ext;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Randomized bench for lsu_mem_stage with a word-array RAM model and arithmetic reference.
module tb_lsu_mem_stage;

    localparam int ADDR_W  = 10;
    localparam int TIMEOUT = 16;

    logic              CLOCK = 1'b0;
    logic              RST_n = 1'b0;
    logic              ena_rd = 1'b0, ena_wr = 1'b0, MemtoReg_sig = 1'b0;
    logic [2:0]        funct3 = '0;
    logic [31:0]       alu_out_ext = '0, dataram_wr = '0;
    logic [31:0]       datareg_wr;
    logic              stall;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_re, mem_we;
    logic [31:0]       mem_rdata = '0;
    logic              mem_ready = 1'b0;
    logic              misaligned_err, bus_err;

    lsu_mem_stage #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .CLOCK(CLOCK), .RST_n(RST_n), .ena_rd(ena_rd), .ena_wr(ena_wr),
        .MemtoReg_sig(MemtoReg_sig), .funct3(funct3), .alu_out_ext(alu_out_ext),
        .dataram_wr(dataram_wr), .datareg_wr(datareg_wr), .stall(stall),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .misaligned_err(misaligned_err), .bus_err(bus_err)
    );

    always #5 CLOCK = ~CLOCK;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [31:0] ram [0:(1<<ADDR_W)-1];
    bit misal_m = 0, bus_m = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Access width in bytes from the ISA meaning of funct3.
    function automatic int nbytes(input logic [2:0] f3, input bit st);
        if (f3 == 3'b000 || (!st && f3 == 3'b100)) return 1;
        if (f3 == 3'b001 || (!st && f3 == 3'b101)) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] load_ref(input logic [31:0] word, input logic [31:0] addr,
                                             input logic [2:0] f3);
        int unsigned off = addr % 4;
        int unsigned v;
        case (nbytes(f3, 0))
            1: begin
                v = (word >> (8 * off)) % 256;
                if (f3 == 3'b000 && v >= 128) v = v + 32'hFFFF_FF00;
            end
            2: begin
                v = (word >> (8 * off)) % 65536;
                if (f3 == 3'b001 && v >= 32768) v = v + 32'hFFFF_0000;
            end
            default: v = word;
        endcase
        return v;
    endfunction

    task automatic xfer(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] d, input int delay, output logic [31:0] obs);
        int sz = nbytes(f3, st);
        int unsigned off = addr % 4;
        bit al = (addr % sz) == 0;
        int unsigned idx = (addr / 4) % (1 << ADDR_W);
        logic [3:0] be_e;
        logic [31:0] wd_e, wb_e;
        int strobes = 0;
        bit ok = 0, done = 0;

        case (sz)
            1: begin be_e = 4'(1 << off); wd_e = (d % 256) * 32'h0101_0101; end
            2: begin be_e = 4'(3 << off); wd_e = (d % 65536) * 32'h0001_0001; end
            default: begin be_e = 4'hF; wd_e = d; end
        endcase

        @(negedge CLOCK);
        ena_wr = st; ena_rd = !st; funct3 = f3; alu_out_ext = addr;
        dataram_wr = d; MemtoReg_sig = !st;
        #1 check("req_stall", 32'(stall), 32'(al));

        if (!al) begin
            @(negedge CLOCK);
            misal_m = 1;
            check("misal_flag", 32'(misaligned_err), 32'd1);
            check("misal_strobe", {mem_re, mem_we}, 32'd0);
            check("misal_stall", 32'(stall), 32'd0);
            check("misal_wb", datareg_wr, st ? addr : 32'd0);
            obs = datareg_wr;
            ena_rd = 0; ena_wr = 0;
            return;
        end

        @(negedge CLOCK);
        check("addr", 32'(mem_addr), idx);
        check("be", 32'(mem_be), 32'(be_e));
        check("wdata", mem_wdata, wd_e);
        check("strobe_kind", {mem_re, mem_we}, st ? 32'd1 : 32'd2);

        for (int k = 0; k < TIMEOUT && !done; k++) begin
            if (k > 0) @(negedge CLOCK);
            strobes += st ? int'(mem_we) : int'(mem_re);
            check("acc_stall", 32'(stall), 32'd1);
            if (k == delay) begin
                mem_ready = 1; mem_rdata = ram[idx]; ok = 1; done = 1;
            end else begin
                mem_rdata = $urandom;
                if (k == TIMEOUT - 1) done = 1;
            end
            @(posedge CLOCK);
        end
        @(negedge CLOCK);
        mem_ready = 0;

        check("strobe_cycles", strobes, ok ? delay + 1 : TIMEOUT);
        check("done_stall", 32'(stall), 32'd0);
        check("done_strobe", {mem_re, mem_we}, 32'd0);

        if (st) wb_e = addr;
        else    wb_e = ok ? load_ref(ram[idx], addr, f3) : 32'hDEAD_BEEF;
        if (ok && st)
            for (int b = 0; b < 4; b++)
                if (be_e[b]) ram[idx][8*b +: 8] = wd_e[8*b +: 8];
        if (!ok) bus_m = 1;

        check("wb", datareg_wr, wb_e);
        check("bus_err", 32'(bus_err), 32'(bus_m));
        check("misal_sticky", 32'(misaligned_err), 32'(misal_m));
        obs = datareg_wr;
        ena_rd = 0; ena_wr = 0;

        @(negedge CLOCK);
        check("idle_stall", 32'(stall), 32'd0);
    endtask

    logic [31:0] obs;

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = $urandom;

        repeat (3) @(negedge CLOCK);
        MemtoReg_sig = 1;
        #1;
        check("rst_strobe", {mem_re, mem_we}, 32'd0);
        check("rst_be", 32'(mem_be), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_flags", {misaligned_err, bus_err}, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_loadq", datareg_wr, 32'd0);
        RST_n = 1;

        ram[4] = 32'h8765_4321;
        xfer(0, 3'b010, 32'h10, 0, 0, obs);
        check("lw_const", obs, 32'h8765_4321);
        ram[4] = 32'h80AA_BBCC;
        xfer(0, 3'b000, 32'h13, 0, 0, obs);
        check("lb_const", obs, 32'hFFFF_FF80);
        xfer(0, 3'b100, 32'h13, 0, 1, obs);
        check("lbu_const", obs, 32'h0000_0080);
        xfer(0, 3'b001, 32'h12, 0, 0, obs);
        check("lh_const", obs, 32'hFFFF_80AA);
        xfer(1, 3'b001, 32'h22, 32'h1234_BEEF, 2, obs);
        xfer(0, 3'b010, 32'h02, 0, 0, obs);
        xfer(0, 3'b010, 32'h20, 0, 0, obs);
        check("misal_kept", 32'(misaligned_err), 32'd1);
        xfer(0, 3'b010, 32'h24, 0, 99, obs);
        check("timeout_const", obs, 32'hDEAD_BEEF);

        // Reset during the second ACCESS cycle.
        @(negedge CLOCK);
        ena_rd = 1; funct3 = 3'b010; alu_out_ext = 32'h10; MemtoReg_sig = 1;
        @(negedge CLOCK);
        @(negedge CLOCK);
        RST_n = 0; ena_rd = 0;
        @(negedge CLOCK);
        check("mid_rst_re", 32'(mem_re), 32'd0);
        check("mid_rst_stall", 32'(stall), 32'd0);
        check("mid_rst_flags", {misaligned_err, bus_err}, 32'd0);
        check("mid_rst_addr", 32'(mem_addr), 32'd0);
        RST_n = 1; misal_m = 0; bus_m = 0;
        ram[4] = 32'h0BAD_F00D;
        xfer(0, 3'b010, 32'h10, 0, 1, obs);
        check("post_rst_lw", obs, 32'h0BAD_F00D);

        for (int n = 0; n < 200; n++) begin
            int dly = ($urandom % 6 == 0) ? 16 + $urandom % 4 : $urandom % 5;
            xfer(bit'($urandom % 2), 3'($urandom % 8), $urandom, $urandom, dly, obs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
